pic_control_core: RTL

Parametrised interrupt-controller core: request latching, masking, rotating-priority resolution, in-service tracking, and the INTA acknowledge sequencer with vector output. It generalises the existing 8-line control logic to NUM_IRQ lines and adds both 8080-mode (3-pulse CALL) and 8086-mode (2-pulse) acknowledge. It sits between the bus/command decoder, which supplies configuration and command strobes, and the CPU-side INT/INTA/data pins.

---
 rtl/pic_pkg.sv | 25 ++
 rtl/pic_control_core_if.sv | 23 ++
 rtl/pic_priority_resolver.sv | 27 ++
 rtl/pic_control_core.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared types, constants and rotating-priority helpers for the interrupt-controller core.
// Latency: none, declarations and pure functions only.
// Backpressure: not applicable.
package pic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK1 = 2'd1,
    ACK2 = 2'd2,
    ACK3 = 2'd3
  } ack_state_t;

  localparam logic [7:0] CALL_OPCODE = 8'hCD;

  // Rank of a level under the current rotation: 0 is the highest priority.
  function automatic int prio_rank(input int level, input int rot_ptr, input int num_irq);
    return (level - rot_ptr - 1 + num_irq) % num_irq;
  endfunction

  // Level that sits at a given rank under the current rotation.
  function automatic int prio_level(input int rank, input int rot_ptr, input int num_irq);
    return (rot_ptr + 1 + rank) % num_irq;
  endfunction

endpackage

// File: rtl/pic_control_core_if.sv
// CPU-side acknowledge bus: INT request out, INTA strobe in, vector byte with drive enable.
// Latency: wires only.
// Backpressure: none, the CPU paces the sequence with INTA pulses.
interface pic_control_core_if;
  logic       inta_n;
  logic       int_out;
  logic [7:0] data_out;
  logic       data_out_en;

  modport master (
    output inta_n,
    input  int_out,
    input  data_out,
    input  data_out_en
  );

  modport slave (
    input  inta_n,
    output int_out,
    output data_out,
    output data_out_en
  );
endinterface

// File: rtl/pic_priority_resolver.sv
// Finds the highest-priority set bit of a request vector under a rotating priority pointer.
// Latency: combinational.
// Backpressure: not applicable.
module pic_priority_resolver
  import pic_pkg::*;
#(
  parameter  int NUM_IRQ = 8,
  localparam int LVL_W   = $clog2(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] req,
  input  logic [LVL_W-1:0]   rot_ptr,
  output logic               found,
  output logic [LVL_W-1:0]   level
);

  // Walk from lowest to highest priority so the last hit is the winner.
  always_comb begin
    found = |req;
    level = '0;
    for (int r = NUM_IRQ - 1; r >= 0; r--) begin
      if (req[prio_level(r, int'(rot_ptr), NUM_IRQ)]) begin
        level = LVL_W'(prio_level(r, int'(rot_ptr), NUM_IRQ));
      end
    end
  end

endmodule

// File: rtl/pic_control_core.sv
// Interrupt-controller core: request latch, mask, rotating priority, in-service and INTA sequencer.
// Latency: irr 1 cycle after irq edge, int_out 1 cycle later; data byte 1 cycle after INTA edge.
// Backpressure: none; PIC_SPECIAL_MASK_EN enables special mask mode via smm.
module pic_control_core
  import pic_pkg::*;
#(
  parameter  int NUM_IRQ = 8,
  localparam int LVL_W   = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               ltim,
  input  logic               upm,
  input  logic               aeoi,
  input  logic               auto_rotate,
  input  logic [7:0]         vector_base,
  input  logic [7:0]         vector_high,
  input  logic               imr_we,
  input  logic [NUM_IRQ-1:0] imr_wdata,
  input  logic               eoi_we,
  input  logic               eoi_specific,
  input  logic [LVL_W-1:0]   eoi_level,
  input  logic               eoi_rotate,
  input  logic               smm,
  pic_control_core_if.slave  cpu,
  output logic [NUM_IRQ-1:0] isr,
  output logic [NUM_IRQ-1:0] irr,
  output logic [NUM_IRQ-1:0] imr
);

  localparam logic [NUM_IRQ-1:0] ONE_HOT = {{(NUM_IRQ-1){1'b0}}, 1'b1};

  ack_state_t         state_q, state_d;
  logic [NUM_IRQ-1:0] prev_irq_q, prev_irq_d;
  logic               prev_inta_q, prev_inta_d;
  logic [NUM_IRQ-1:0] irr_q, irr_d;
  logic [NUM_IRQ-1:0] isr_q, isr_d;
  logic [NUM_IRQ-1:0] imr_q, imr_d;
  logic [LVL_W-1:0]   rot_ptr_q, rot_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               spurious_q, spurious_d;
  logic [7:0]         data_out_q, data_out_d;
  logic               data_out_en_q, data_out_en_d;
  logic               int_out_q, int_out_d;

  logic [NUM_IRQ-1:0] req_vec, isr_cmp;
  logic               req_found, isr_found;
  logic [LVL_W-1:0]   req_level, isr_level;
  logic               inta_fall, inta_rise;
  logic [NUM_IRQ-1:0] ack_set, aeoi_clr, eoi_clr;
  logic               seq_end, eoi_hit;
  logic [LVL_W-1:0]   eoi_lvl;
  logic [7:0]         vec;

  assign req_vec   = irr_q & ~imr_q;
  assign inta_fall = prev_inta_q & ~cpu.inta_n;
  assign inta_rise = ~prev_inta_q & cpu.inta_n;

`ifdef PIC_SPECIAL_MASK_EN
  // Masked in-service levels drop out of nesting so lower levels can interrupt them.
  assign isr_cmp = smm ? (isr_q & ~imr_q) : isr_q;
`else
  logic smm_unused;
  assign smm_unused = smm;
  assign isr_cmp    = isr_q;
`endif

  pic_priority_resolver #(.NUM_IRQ(NUM_IRQ)) u_req_res (
    .req     (req_vec),
    .rot_ptr (rot_ptr_q),
    .found   (req_found),
    .level   (req_level)
  );

  pic_priority_resolver #(.NUM_IRQ(NUM_IRQ)) u_isr_res (
    .req     (isr_cmp),
    .rot_ptr (rot_ptr_q),
    .found   (isr_found),
    .level   (isr_level)
  );

  // Acknowledge sequencer: next state, level latch and data byte selection.
  always_comb begin
    state_d       = state_q;
    level_d       = level_q;
    spurious_d    = spurious_q;
    data_out_d    = data_out_q;
    data_out_en_d = data_out_en_q;
    ack_set       = '0;
    seq_end       = 1'b0;
    vec           = vector_base;
    vec[LVL_W-1:0] = level_q;
    case (state_q)
      IDLE: begin
        if (inta_fall) begin
          state_d = ACK1;
          if (req_found) begin
            level_d    = req_level;
            spurious_d = 1'b0;
            ack_set    = ONE_HOT << req_level;
          end else begin
            level_d    = '1;
            spurious_d = 1'b1;
          end
          if (upm) begin
            data_out_d    = 8'h00;
            data_out_en_d = 1'b0;
          end else begin
            data_out_d    = CALL_OPCODE;
            data_out_en_d = 1'b1;
          end
        end
      end
      ACK1: begin
        if (inta_rise) begin
          state_d       = ACK2;
          data_out_d    = 8'h00;
          data_out_en_d = 1'b0;
        end
      end
      ACK2: begin
        if (inta_fall) begin
          data_out_d    = vec;
          data_out_en_d = 1'b1;
        end else if (inta_rise) begin
          data_out_d    = 8'h00;
          data_out_en_d = 1'b0;
          if (upm) begin
            state_d = IDLE;
            seq_end = 1'b1;
          end else begin
            state_d = ACK3;
          end
        end
      end
      ACK3: begin
        if (inta_fall) begin
          data_out_d    = vector_high;
          data_out_en_d = 1'b1;
        end else if (inta_rise) begin
          state_d       = IDLE;
          seq_end       = 1'b1;
          data_out_d    = 8'h00;
          data_out_en_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // In-service clears from EOI and AEOI, plus rotation; EOI rotation overrides AEOI rotation.
  always_comb begin
    eoi_hit  = 1'b0;
    eoi_lvl  = isr_level;
    eoi_clr  = '0;
    aeoi_clr = '0;
    rot_ptr_d = rot_ptr_q;
    // A spurious acknowledge serviced nothing, so it must not retire or rotate a level.
    if (seq_end && aeoi && !spurious_q) begin
      aeoi_clr = ONE_HOT << level_q;
      if (auto_rotate) rot_ptr_d = level_q;
    end
    if (eoi_we) begin
      if (eoi_specific) begin
        eoi_lvl = eoi_level;
        eoi_hit = isr_q[eoi_level];
      end else begin
        eoi_lvl = isr_level;
        eoi_hit = isr_found;
      end
    end
    if (eoi_hit) begin
      eoi_clr = ONE_HOT << eoi_lvl;
      if (eoi_rotate) rot_ptr_d = eoi_lvl;
    end
  end

  // Request, mask and in-service registers, edge history and the CPU interrupt line.
  always_comb begin
    prev_irq_d  = irq;
    prev_inta_d = cpu.inta_n;
    imr_d       = imr_we ? imr_wdata : imr_q;
    irr_d       = ltim ? irq : ((irr_q & ~ack_set) | (irq & ~prev_irq_q));
    isr_d       = (isr_q & ~(eoi_clr | aeoi_clr)) | ack_set;
    int_out_d   = req_found &&
                  (!isr_found ||
                   (prio_rank(int'(req_level), int'(rot_ptr_q), NUM_IRQ) <
                    prio_rank(int'(isr_level), int'(rot_ptr_q), NUM_IRQ)));
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      prev_irq_q    <= '0;
      prev_inta_q   <= 1'b1;
      irr_q         <= '0;
      isr_q         <= '0;
      imr_q         <= '1;
      rot_ptr_q     <= LVL_W'(NUM_IRQ - 1);
      level_q       <= '0;
      spurious_q    <= 1'b0;
      data_out_q    <= 8'h00;
      data_out_en_q <= 1'b0;
      int_out_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev_irq_q    <= prev_irq_d;
      prev_inta_q   <= prev_inta_d;
      irr_q         <= irr_d;
      isr_q         <= isr_d;
      imr_q         <= imr_d;
      rot_ptr_q     <= rot_ptr_d;
      level_q       <= level_d;
      spurious_q    <= spurious_d;
      data_out_q    <= data_out_d;
      data_out_en_q <= data_out_en_d;
      int_out_q     <= int_out_d;
    end
  end

  assign cpu.int_out     = int_out_q;
  assign cpu.data_out    = data_out_q;
  assign cpu.data_out_en = data_out_en_q;
  assign isr = isr_q;
  assign irr = irr_q;
  assign imr = imr_q;

endmodule
